// File: rtl/btn_event_in_if.sv
// MIO bus slot seen by the button/event input peripheral.
// The CPU side drives strobes and write data; the peripheral returns read data combinationally.
interface btn_event_in_if;
  logic        en;
  logic        we;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output en, we, rd, addr, data_in, input data_out);
  modport slave  (input en, we, rd, addr, data_in, output data_out);
endinterface

// File: rtl/btn_event_in.sv
// Button edge event FIFO with timestamps, switch/status readback and control register.
// The CPU drains events by reading the EVENT word; irq flags a non-empty queue while enabled.
module btn_event_in #(
  parameter int DEPTH  = 8,
  parameter int TS_DIV = 1024
) (
  input  logic          clk,
  input  logic          rst,
  btn_event_in_if.slave bus,
  input  logic [3:0]    BTN,
  input  logic [15:0]   SW,
  output logic          irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(TS_DIV - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          enable;
  logic [14:0]   ts;
  logic [PW-1:0] pre;
  logic [3:0]    btn_s;
  logic [3:0]    btn_q;
  logic [3:0]    rise;
  logic [3:0]    fall;
  logic          push_req;
  logic          pop;
  logic          ctrl_wr;
  logic          clr_fifo;
  logic          push;
  logic          drop;
  logic [31:0]   ev_word;
  logic          unused_din;

  assign unused_din = ^bus.data_in[31:3];

  // btn_s is the sampled button vector, btn_q the same vector one cycle older
  assign rise     = btn_s & ~btn_q;
  assign fall     = ~btn_s & btn_q;
  assign push_req = enable && ((rise | fall) != 4'b0);
  assign pop      = bus.en && bus.rd && !bus.we && (bus.addr == 2'd0) && (count != '0);
  assign ctrl_wr  = bus.en && bus.we && (bus.addr == 2'd2);
  assign clr_fifo = ctrl_wr && bus.data_in[1];
  assign push     = push_req && !clr_fifo && ((count != FULL) || pop);
  assign drop     = push_req && !clr_fifo && (count == FULL) && !pop;
  assign ev_word  = {1'b1, ts, rise, fall, btn_s, 4'b0};

  always_ff @(posedge clk) begin
    btn_s <= BTN;
    if (rst) begin
      btn_q  <= BTN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      enable <= 1'b1;
      ts     <= '0;
      pre    <= PRE_LOAD;
      irq    <= 1'b0;
    end else begin
      btn_q <= btn_s;
      irq   <= enable && (count != '0);
      // timestamp prescaler counts down; reaching zero is one tick
      if (pre == '0) begin
        pre <= PRE_LOAD;
        ts  <= ts + 15'd1;
      end else begin
        pre <= pre - PW'(1);
      end
      if (ctrl_wr) enable <= bus.data_in[0];
      if (drop) ovf <= 1'b1;
      else if (ctrl_wr && bus.data_in[2]) ovf <= 1'b0;
      if (clr_fifo) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_word;
  end

  always_comb begin
    bus.data_out = 32'h0;
    case (bus.addr)
      2'd0:    if (count != '0) bus.data_out = mem[rd_ptr];
      2'd1:    bus.data_out = {SW, 7'b0, ovf, 8'(count)};
      2'd2:    bus.data_out = {31'b0, enable};
      default: bus.data_out = {17'b0, ts};
    endcase
  end
endmodule

// File: tb/tb_btn_event_in.sv
// Self-checking bench for btn_event_in: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the event FIFO and register map.
`timescale 1ns/1ps
module tb_btn_event_in;
  localparam int DEPTH  = 8;
  localparam int TS_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_f = 1'b1;
  logic [3:0]  BTN = 4'b0001;
  logic [15:0] SW = 16'h0;
  logic        irq;
  logic        irq_f;
  logic [3:0]  btn_f = 4'h0;
  logic [15:0] sw_f = 16'h0;

  int n_checks = 0;
  int n_fail = 0;

  btn_event_in_if b ();
  btn_event_in_if bf ();

  btn_event_in #(.DEPTH(DEPTH), .TS_DIV(TS_DIV)) dut (
    .clk(clk), .rst(rst), .bus(b), .BTN(BTN), .SW(SW), .irq(irq)
  );

  btn_event_in #(.DEPTH(DEPTH), .TS_DIV(1)) dut_fast (
    .clk(clk), .rst(rst_f), .bus(bf), .BTN(btn_f), .SW(sw_f), .irq(irq_f)
  );

  always #10 clk = ~clk;

  // reference model: event queue, flags, cycles since reset, last two button samples
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_en = 1'b1;
  bit          m_irq = 1'b0;
  int          m_cyc = 0;
  logic [3:0]  s1 = 4'h0;
  logic [3:0]  s2 = 4'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] m_ts();
    return 15'((m_cyc / TS_DIV) % 32768);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return (mq.size() != 0) ? mq[0] : 32'h0;
      2'd1:    return {SW, 7'b0, m_ovf, 8'(mq.size())};
      2'd2:    return {31'b0, m_en};
      default: return {17'b0, m_ts()};
    endcase
  endfunction

  task automatic model_edge();
    logic [3:0] r, f;
    bit push, pop, wr;
    int sz;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_en = 1'b1; m_irq = 1'b0; m_cyc = 0;
      s1 = BTN; s2 = BTN;
    end else begin
      sz   = mq.size();
      r    = s1 & ~s2;
      f    = ~s1 & s2;
      push = m_en && ((r | f) != 4'b0);
      pop  = b.en && b.rd && !b.we && (b.addr == 2'd0) && (sz != 0);
      wr   = b.en && b.we && (b.addr == 2'd2);
      m_irq = m_en && (sz != 0);
      if (wr && b.data_in[2]) m_ovf = 1'b0;
      if (wr && b.data_in[1]) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (mq.size() < DEPTH) mq.push_back({1'b1, m_ts(), r, f, s1, 4'b0});
          else m_ovf = 1'b1;
        end
      end
      if (wr) m_en = b.data_in[0];
      m_cyc++;
      s2 = s1;
      s1 = BTN;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic peek(input logic [1:0] a, input string tag);
    b.en = 1'b1; b.rd = 1'b0; b.we = 1'b0; b.addr = a;
    #1;
    check_eq(tag, b.data_out, exp_rd(a));
    check_eq({tag, "_irq"}, 32'(irq), 32'(m_irq));
  endtask

  task automatic pop_chk(input string tag);
    b.en = 1'b1; b.we = 1'b0; b.rd = 1'b1; b.addr = 2'd0;
    #1;
    check_eq(tag, b.data_out, exp_rd(2'd0));
    cyc();
    b.rd = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    b.en = 1'b1; b.we = 1'b1; b.rd = 1'b0; b.addr = 2'd2; b.data_in = d;
    cyc();
    b.we = 1'b0; b.data_in = 32'h0;
  endtask

  task automatic push_edges(input int n);
    for (int i = 0; i < n; i++) begin
      BTN = BTN + 4'd1;
      cyc();
    end
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  logic [31:0] t_before;
  bit          irq_low;

  initial begin
    b.en = 1'b0; b.we = 1'b0; b.rd = 1'b0; b.addr = 2'd0; b.data_in = 32'h0;
    bf.en = 1'b1; bf.we = 1'b0; bf.rd = 1'b0; bf.addr = 2'd3; bf.data_in = 32'h0;

    // reset with a button held: no event, enable comes up set
    @(negedge clk);
    cyc();
    rst = 1'b0;
    peek(2'd1, "t1_status");
    check_eq("t1_count", 32'(b.data_out[7:0]), 32'd0);
    peek(2'd0, "t1_event");
    check_eq("t1_event_zero", b.data_out, 32'h0);
    peek(2'd2, "t1_ctrl");
    check_eq("t1_ctrl_one", b.data_out, 32'd1);
    cyc(); cyc();
    peek(2'd1, "t1_held_status");

    // single edge at ts=5, latency and irq
    BTN = 4'b0000;
    do_reset();
    while (m_cyc < 19) cyc();
    BTN = 4'b0010;
    cyc();
    peek(2'd1, "t2_not_yet");
    check_eq("t2_count0", 32'(b.data_out[7:0]), 32'd0);
    cyc();
    peek(2'd0, "t2_event");
    check_eq("t2_event_word", b.data_out, 32'h8005_2020);
    peek(2'd1, "t2_status");
    check_eq("t2_count1", 32'(b.data_out[7:0]), 32'd1);
    check_eq("t2_irq_low", 32'(irq), 32'd0);
    cyc();
    check_eq("t2_irq_high", 32'(irq), 32'd1);
    pop_chk("t2_pop");
    peek(2'd1, "t2_after_pop");
    check_eq("t2_count_after", 32'(b.data_out[7:0]), 32'd0);
    irq_low = 1'b0;
    for (int k = 0; k < 2 && !irq_low; k++) begin
      cyc();
      irq_low = (irq == 1'b0);
    end
    check_eq("t2_irq_fall", 32'(irq_low), 32'd1);

    // overflow: 9 edges, 8 kept in order
    BTN = 4'b0000;
    do_reset();
    push_edges(9);
    peek(2'd1, "t3_status");
    check_eq("t3_count8", 32'(b.data_out[7:0]), 32'd8);
    check_eq("t3_ovf", 32'(b.data_out[8]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      b.en = 1'b1; b.we = 1'b0; b.rd = 1'b1; b.addr = 2'd0;
      #1;
      check_eq("t3_pop", b.data_out, exp_rd(2'd0));
      check_eq("t3_pop_btn", 32'(b.data_out[7:4]), 32'(i + 1));
      cyc();
      b.rd = 1'b0;
    end
    peek(2'd0, "t3_empty");
    check_eq("t3_empty_zero", b.data_out, 32'h0);
    wr_ctrl(32'h5);
    peek(2'd1, "t3_ovf_clr");
    check_eq("t3_ovf0", 32'(b.data_out[8]), 32'd0);

    // full + pop + edge in one cycle
    push_edges(8);
    BTN = BTN + 4'd1;
    cyc();
    pop_chk("t4_full_pop");
    peek(2'd1, "t4_full_status");
    check_eq("t4_count8", 32'(b.data_out[7:0]), 32'd8);
    check_eq("t4_ovf0", 32'(b.data_out[8]), 32'd0);
    // overflow coincident with ovf clear: set wins
    BTN = BTN + 4'd1;
    cyc();
    wr_ctrl(32'h5);
    peek(2'd1, "t4_setwins");
    check_eq("t4_setwins_ovf", 32'(b.data_out[8]), 32'd1);
    // clear coincident with an edge
    wr_ctrl(32'h7);
    push_edges(3);
    peek(2'd1, "t4_count3");
    check_eq("t4_count3_v", 32'(b.data_out[7:0]), 32'd3);
    BTN = BTN + 4'd1;
    cyc();
    wr_ctrl(32'h3);
    peek(2'd1, "t4_clear");
    check_eq("t4_clear_count", 32'(b.data_out[7:0]), 32'd0);
    check_eq("t4_clear_ovf", 32'(b.data_out[8]), 32'd0);
    cyc();
    peek(2'd1, "t4_clear_after");

    // disabled: no events, timestamp still runs, switches visible
    wr_ctrl(32'h0);
    peek(2'd2, "t5_ctrl");
    check_eq("t5_ctrl0", b.data_out, 32'd0);
    peek(2'd3, "t5_ts0");
    t_before = b.data_out;
    push_edges(6);
    cyc(); cyc();
    peek(2'd1, "t5_status");
    check_eq("t5_count0", 32'(b.data_out[7:0]), 32'd0);
    check_eq("t5_irq0", 32'(irq), 32'd0);
    peek(2'd3, "t5_ts1");
    check_eq("t5_ts_runs", 32'(b.data_out > t_before), 32'd1);
    SW = 16'hA5C3;
    peek(2'd1, "t5_sw");
    check_eq("t5_sw_field", 32'(b.data_out[31:16]), 32'h0000_A5C3);

    // randomized traffic against the model
    wr_ctrl(32'h7);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) BTN = 4'($urandom);
      if ($urandom_range(0, 63) == 0) SW = 16'($urandom);
      b.en      = ($urandom_range(0, 7) != 0);
      b.addr    = 2'($urandom);
      b.rd      = 1'($urandom_range(0, 1));
      b.we      = ($urandom_range(0, 15) == 0);
      b.data_in = $urandom;
      b.data_in[0] = ($urandom_range(0, 7) != 0);
      b.data_in[1] = ($urandom_range(0, 5) == 0);
      #1;
      check_eq("rnd_dout", b.data_out, exp_rd(b.addr));
      check_eq("rnd_irq", 32'(irq), 32'(m_irq));
      cyc();
    end
    b.we = 1'b0; b.rd = 1'b0; b.data_in = 32'h0;

    // reset mid-operation discards queued events
    wr_ctrl(32'h7);
    push_edges(5);
    peek(2'd1, "t6_count5");
    check_eq("t6_count5_v", 32'(b.data_out[7:0]), 32'd5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    peek(2'd1, "t6_after_rst");
    check_eq("t6_count0", 32'(b.data_out[7:0]), 32'd0);

    // timestamp wrap on the TS_DIV=1 instance
    rst_f = 1'b1;
    cyc();
    rst_f = 1'b0;
    for (int n = 1; n <= 32768; n++) begin
      cyc();
      if (n == 1 || n == 32767 || n == 32768) begin
        #1;
        check_eq("t6_ts_wrap", bf.data_out, 32'(n % 32768));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
